// File: rtl/calendar_pkg.sv
// Shared calendar definitions: month codes, days-per-month table, leap rule.
package calendar_pkg;

    localparam logic [1:0] SET_MONTH = 2'd2;
    localparam logic [3:0] MONTHS    = 4'd12;

    typedef enum logic [3:0] {
        JAN = 4'd1,  FEB = 4'd2,  MAR = 4'd3,  APR = 4'd4,
        MAY = 4'd5,  JUN = 4'd6,  JUL = 4'd7,  AUG = 4'd8,
        SEP = 4'd9,  OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
    } month_e;

    // February entry is the common-year value; leap years override it.
    localparam logic [4:0] DAYS_IN_MONTH [1:12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    // Gregorian leap rule; year 0 is divisible by 400 and so counts as leap.
    function automatic logic is_leap(input logic [13:0] y);
        return ((y % 14'd4) == 14'd0) &&
               (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
    endfunction

endpackage

// File: rtl/month_if.sv
// Bus between the month stage and its neighbours (keys, day/year stages, display).
interface month_if;
    logic        up;
    logic [1:0]  set;
    logic        day_carry;
    logic [13:0] year_count;
    logic [3:0]  month_count;
    logic        month_carry;
    logic [4:0]  day_case;
    logic [13:0] month_7seg;

    modport master (
        output up, set, day_carry, year_count,
        input  month_count, month_carry, day_case, month_7seg
    );

    modport slave (
        input  up, set, day_carry, year_count,
        output month_count, month_carry, day_case, month_7seg
    );
endinterface

// File: rtl/month_days_lut.sv
// Combinational days-in-month lookup. Out-of-range month codes fall back to 31.
module month_days_lut
    import calendar_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [4:0] days
);

    // Table lookup with a February override in leap years
    always_comb begin
        days = 5'd31;
        if ((month >= JAN) && (month <= DEC)) begin
            if ((month == FEB) && leap) begin
                days = 5'd29;
            end else begin
                days = DAYS_IN_MONTH[month];
            end
        end else begin
            days = 5'd31;
        end
    end

endmodule

// File: rtl/month_display.sv
// Two-digit display helpers: binary to BCD and BCD to active-low 7-segment (gfedcba).
module binary_to_bcd_8bit (
    input  logic [7:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    // Only two digits are displayed, so the hundreds place is dropped
    always_comb begin
        tens_o  = 4'((bin_i % 8'd100) / 8'd10);
        units_o = 4'(bin_i % 8'd10);
    end

endmodule

module bcd_to_7segment (
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Decode one digit; blank_i suppresses a leading zero, invalid codes go dark
    always_comb begin
        seg_o = 7'b1111111;
        if (blank_i && (bcd_i == 4'd0)) begin
            seg_o = 7'b1111111;
        end else begin
            case (bcd_i)
                4'd0:    seg_o = 7'b1000000;
                4'd1:    seg_o = 7'b1111001;
                4'd2:    seg_o = 7'b0100100;
                4'd3:    seg_o = 7'b0110000;
                4'd4:    seg_o = 7'b0011001;
                4'd5:    seg_o = 7'b0010010;
                4'd6:    seg_o = 7'b0000010;
                4'd7:    seg_o = 7'b1111000;
                4'd8:    seg_o = 7'b0000000;
                4'd9:    seg_o = 7'b0010000;
                default: seg_o = 7'b1111111;
            endcase
        end
    end

endmodule

// File: rtl/month.sv
// Month-of-year counter (1..12). Advances on a day_carry rise in run mode or an
// up rise in month-set mode, reports the month length and drives two 7-seg digits.
// Build option: define LEAP_YEAR_EN to apply the leap rule to February;
// otherwise February is always 28 days and year_count is not used.
module month
    import calendar_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    month_if.slave  bus
);

    logic       up_q;
    logic       day_carry_q;
    logic [3:0] month_count_q;
    logic [3:0] month_count_d;
    logic       month_carry_q;
    logic       month_carry_d;
    logic [4:0] day_case_q;
    logic [4:0] days_s;
    logic       leap_s;
    logic       adv_s;
    logic [3:0] tens_s;
    logic [3:0] units_s;
    logic [6:0] tens_seg_s;
    logic [6:0] units_seg_s;

    // Select the advance source from the set code and compute the next month
    always_comb begin
        adv_s         = 1'b0;
        month_count_d = month_count_q;
        month_carry_d = 1'b0;
        case (bus.set)
            2'b00:     adv_s = bus.day_carry & ~day_carry_q;
            SET_MONTH: adv_s = bus.up & ~up_q;
            default:   adv_s = 1'b0;
        endcase
        if (adv_s) begin
            if (month_count_q < MONTHS) begin
                month_count_d = month_count_q + 4'd1;
            end else begin
                month_count_d = JAN;
                // Only a calendar roll-over (not a manual set) carries into the year
                month_carry_d = (bus.set == 2'b00);
            end
        end else begin
            month_count_d = month_count_q;
        end
    end

`ifdef LEAP_YEAR_EN
    // February length depends on the current year
    always_comb begin
        leap_s = is_leap(bus.year_count);
    end
`else
    // February is fixed at 28 days in this build
    always_comb begin
        leap_s = 1'b0;
    end
`endif

    month_days_lut u_days (
        .month (month_count_q),
        .leap  (leap_s),
        .days  (days_s)
    );

    // State registers: edge-detect history, month counter, carry pulse, month length
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            up_q          <= 1'b0;
            day_carry_q   <= 1'b0;
            month_count_q <= JAN;
            month_carry_q <= 1'b0;
            day_case_q    <= 5'd31;
        end else begin
            up_q          <= bus.up;
            day_carry_q   <= bus.day_carry;
            month_count_q <= month_count_d;
            month_carry_q <= month_carry_d;
            day_case_q    <= days_s;
        end
    end

    binary_to_bcd_8bit u_bcd (
        .bin_i   ({4'd0, month_count_q}),
        .tens_o  (tens_s),
        .units_o (units_s)
    );

    bcd_to_7segment u_seg_units (
        .bcd_i   (units_s),
        .blank_i (1'b0),
        .seg_o   (units_seg_s)
    );

    bcd_to_7segment u_seg_tens (
        .bcd_i   (tens_s),
        .blank_i (1'b1),
        .seg_o   (tens_seg_s)
    );

    assign bus.month_count = month_count_q;
    assign bus.month_carry = month_carry_q;
    assign bus.day_case    = day_case_q;
    assign bus.month_7seg  = {tens_seg_s, units_seg_s};

endmodule
